alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_comb.sv | 27 ++
 rtl/alu_exec_unit.sv | 128 ++++++++++++
 tb/tb_alu_exec_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU decoder codes and execution-unit FSM state encoding.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_ILL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational add/sub/and/or/slt datapath; any other code reports illegal.
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            legal
);

  always_comb begin
    result = '0;
    legal  = 1'b1;
    case (alu_ctrl_e'(alu_control))
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: IDLE -> EXEC -> DONE with a registered result.
// Define ALU_SHIFT_EN to add iterative sll/srl (codes 110/111), one bit per EXEC cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic            illegal
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              zero_q, zero_d;
  logic              ill_q, ill_d;

  logic [XLEN-1:0]   comb_result;
  logic              comb_legal;

  alu_comb #(.XLEN(XLEN)) u_alu_comb (
    .alu_control (op_q),
    .src_a       (a_q),
    .src_b       (b_q),
    .result      (comb_result),
    .legal       (comb_legal)
  );

`ifdef ALU_SHIFT_EN
  logic              is_shift;
  logic [XLEN-1:0]   shifted;
  assign is_shift = (op_q == ALU_SLL) || (op_q == ALU_SRL);
  assign shifted  = (op_q == ALU_SLL) ? (a_q << 1) : (a_q >> 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = ALUControl;
          a_d     = SrcA;
          b_d     = SrcB;
          cnt_d   = SrcB[4:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = comb_result;
        ill_d   = ~comb_legal;
        cnt_d   = '0;
        state_d = S_DONE;
`ifdef ALU_SHIFT_EN
        // The operand register doubles as the shift accumulator; the last
        // step is folded into the result load so n shifts take n EXEC cycles.
        if (is_shift) begin
          ill_d = 1'b0;
          if (cnt_q > 5'd1) begin
            a_d     = shifted;
            cnt_d   = cnt_q - 5'd1;
            res_d   = res_q;
            ill_d   = ill_q;
            state_d = S_EXEC;
          end else begin
            res_d = (cnt_q == 5'd1) ? shifted : a_q;
          end
        end
`endif
        zero_d = (res_d == '0);
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; shift vectors only when ALU_SHIFT_EN is defined.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        illegal;

  int totalChecks = 0;
  int badChecks   = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request for a single accepting edge, then scramble the inputs
  // so any late sampling of them by the DUT shows up in the result.
  task automatic applyStimulus(input logic [2:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    in_valid   = 1'b1;
    ALUControl = ctrl;
    SrcA       = a;
    SrcB       = b;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    ALUControl = 3'b000;
    SrcA       = $urandom;
    SrcB       = $urandom;
  endtask

  // Latency counts cycles from the accept cycle to the first cycle with
  // out_valid high: 2 for single-cycle codes, shamt+1 for shifts.
  task automatic runOp(input string tag, input logic [2:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input logic expIll,
                       input int expLat, input int holdCycles);
    int lat;
    applyStimulus(ctrl, a, b);
    lat = 1;
    checkOutput({tag, " in_ready busy"}, {31'd0, in_ready}, 32'd0);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " result"}, ALUResult, expRes);
    checkOutput({tag, " zero"}, {31'd0, Zero}, {31'd0, (expRes == 32'd0)});
    checkOutput({tag, " illegal"}, {31'd0, illegal}, {31'd0, expIll});
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, " hold ready"}, {31'd0, in_ready}, 32'd0);
      checkOutput({tag, " hold result"}, ALUResult, expRes);
      checkOutput({tag, " hold illegal"}, {31'd0, illegal}, {31'd0, expIll});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, " back idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 3'b000;
    SrcA       = 32'd0;
    SrcB       = 32'd0;
    #12;
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset result", ALUResult, 32'd0);
    checkOutput("reset zero", {31'd0, Zero}, 32'd1);
    checkOutput("reset illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("add 5+7",   3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 2, 0);
    runOp("sub 9-9",   3'b001, 32'd9, 32'd9, 32'd0, 1'b0, 2, 0);
    runOp("sub 0-1",   3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 2, 0);
    runOp("and",       3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 2, 0);
    runOp("or",        3'b011, 32'h00FF_0000, 32'h0000_FF00, 32'h00FF_FF00, 1'b0, 2, 0);
    runOp("slt -1<1",  3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 2, 5);
    runOp("slt 1<-1",  3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 2, 0);
    runOp("code 100",  3'b100, 32'd5, 32'd7, 32'd0, 1'b1, 2, 0);
`ifdef ALU_SHIFT_EN
    runOp("sll 1<<31", 3'b110, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 32, 0);
    runOp("srl by 0",  3'b111, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 2, 0);
    runOp("srl by 4",  3'b111, 32'hF000_00F0, 32'd4, 32'h0F00_000F, 1'b0, 5, 0);
`else
    runOp("code 110",  3'b110, 32'd1, 32'd31, 32'd0, 1'b1, 2, 0);
    runOp("code 111",  3'b111, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 2, 0);
`endif

    // Abort a long operation with reset partway through.
    applyStimulus(3'b110, 32'd1, 32'd20);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("abort in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort result", ALUResult, 32'd0);
    checkOutput("abort zero", {31'd0, Zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("add after abort", 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 2, 0);
    runOp("add wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
